// File: rtl/sensor_conditioner.sv
// Vehicle detector front end: synchroniser, debouncer, request latch,
// timer tick prescaler and stuck-detector fail-safe.
module sensor_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 8,
  parameter int DEB_W       = 4,
  parameter int TICK_DIV    = 50,
  parameter int TICK_W      = 6,
  parameter int STUCK_LIMIT = 200,
  parameter int STUCK_W     = 8
) (
  input  logic clk,
  input  logic R,
  input  logic car_raw,
  input  logic run,
  input  logic serve,
  output logic C,
  output logic EN,
  output logic det,
  output logic stuck
);

  localparam logic [DEB_W-1:0] DEB_LAST =
    DEB_W'(DEB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST =
    TICK_W'(TICK_DIV - 1);
  localparam logic [STUCK_W-1:0] STK_MAX =
    STUCK_W'(STUCK_LIMIT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_car;
  logic [DEB_W-1:0]       deb_cnt;
  logic                   det_d;
  logic                   req_q;
  logic [TICK_W-1:0]      pre_cnt;
  logic [STUCK_W-1:0]     stk_cnt;

  assign s_car = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], car_raw};
    end
  end

  // Level changes only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      deb_cnt <= '0;
      det     <= 1'b0;
    end else if (s_car == det) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      det     <= s_car;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      det_d <= 1'b0;
      req_q <= 1'b0;
    end else begin
      det_d <= det;
      if (det && !det_d) begin
        req_q <= 1'b1;
      end else if (serve) begin
        req_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      pre_cnt <= '0;
      EN      <= 1'b0;
    end else if (!run) begin
      EN <= 1'b0;
    end else if (pre_cnt == TICK_LAST) begin
      pre_cnt <= '0;
      EN      <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + TICK_W'(1);
      EN      <= 1'b0;
    end
  end

  // Ticks of continuous detection, saturating at the limit
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      stk_cnt <= '0;
    end else if (!det) begin
      stk_cnt <= '0;
    end else if (EN && (stk_cnt != STK_MAX)) begin
      stk_cnt <= stk_cnt + STUCK_W'(1);
    end
  end

  assign stuck = (stk_cnt == STK_MAX);
  assign C     = req_q | stuck;

endmodule
